// File: rtl/fp_seq_pkg.sv
// Shared definitions for the float-unit gain sequencer: float-unit op codes
// and the sequencer FSM state type.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_DIV = 3'd2,
    OP_MUL = 3'd3,
    OP_F2I = 3'd4,
    OP_I2F = 3'd5
  } fp_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I2F,
    ST_GAP1,
    ST_MUL,
    ST_GAP2,
    ST_F2I,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/fp_gain_sequencer_if.sv
// Bundle of sample stream and float-unit signals for fp_gain_sequencer.
// master = sequencer side, slave = environment (source, sink, float unit).
interface fp_gain_sequencer_if #(
  parameter int SAMPLE_W = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_sample;
  logic [31:0]         gain;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_sample;
  logic [2:0]          fp_operation;
  logic                fp_clk_en;
  logic [31:0]         fp_dataa;
  logic [31:0]         fp_datab;
  logic [31:0]         fp_result;
  logic                fp_done;
  logic                err;

  modport master (
    input  in_valid, in_sample, gain, out_ready, fp_result, fp_done,
    output in_ready, out_valid, out_sample, fp_operation, fp_clk_en,
           fp_dataa, fp_datab, err
  );

  modport slave (
    output in_valid, in_sample, gain, out_ready, fp_result, fp_done,
    input  in_ready, out_valid, out_sample, fp_operation, fp_clk_en,
           fp_dataa, fp_datab, err
  );
endinterface

// File: rtl/fp_sat_clip.sv
// Clamps a 32-bit signed integer into the signed SAMPLE_W-bit range.
module fp_sat_clip #(
  parameter int SAMPLE_W = 24
) (
  input  logic [31:0]         value,
  output logic [SAMPLE_W-1:0] clipped
);
  localparam logic signed [31:0] MAX_V = (32'sd1 <<< (SAMPLE_W - 1)) - 32'sd1;
  localparam logic signed [31:0] MIN_V = -(32'sd1 <<< (SAMPLE_W - 1));

  logic signed [31:0] v;

  always_comb begin
    v = signed'(value);
    if (v > MAX_V)
      clipped = MAX_V[SAMPLE_W-1:0];
    else if (v < MIN_V)
      clipped = MIN_V[SAMPLE_W-1:0];
    else
      clipped = v[SAMPLE_W-1:0];
  end
endmodule

// File: rtl/fp_gain_sequencer.sv
// Scales one integer sample by a float gain using an external float unit:
// I2F -> MUL -> F2I, with a one-cycle enable drop between ops, then saturates.
module fp_gain_sequencer
  import fp_seq_pkg::*;
#(
  parameter int SAMPLE_W    = 24,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                 clock,
  input logic                 reset_n,
  fp_gain_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state;
  fp_op_t              op_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [31:0]         gain_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [SAMPLE_W-1:0] out_sample_q;
  logic                clk_en_q;
  logic [31:0]         dataa_q;
  logic [31:0]         datab_q;
  logic                err_q;
  logic [SAMPLE_W-1:0] clipped;

  fp_sat_clip #(.SAMPLE_W(SAMPLE_W)) u_sat (
    .value   (bus.fp_result),
    .clipped (clipped)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sample   = out_sample_q;
  assign bus.fp_operation = op_q;
  assign bus.fp_clk_en    = clk_en_q;
  assign bus.fp_dataa     = dataa_q;
  assign bus.fp_datab     = datab_q;
  assign bus.err          = err_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_ADD;
      wait_cnt     <= '0;
      gain_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      clk_en_q     <= 1'b0;
      dataa_q      <= '0;
      datab_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            gain_q     <= bus.gain;
            dataa_q    <= 32'(signed'(bus.in_sample));
            datab_q    <= '0;
            op_q       <= OP_I2F;
            clk_en_q   <= 1'b1;
            in_ready_q <= 1'b0;
            wait_cnt   <= '0;
            state      <= ST_I2F;
          end
        end
        ST_I2F, ST_MUL, ST_F2I: begin
          if (bus.fp_done) begin
            clk_en_q <= 1'b0;
            op_q     <= OP_ADD;
            wait_cnt <= '0;
            // Next op's operands are loaded during the gap, so they are
            // already stable when the enable comes back up.
            case (state)
              ST_I2F: begin
                dataa_q <= bus.fp_result;
                datab_q <= gain_q;
                state   <= ST_GAP1;
              end
              ST_MUL: begin
                dataa_q <= bus.fp_result;
                datab_q <= '0;
                state   <= ST_GAP2;
              end
              default: begin
                dataa_q      <= '0;
                datab_q      <= '0;
                out_sample_q <= clipped;
                out_valid_q  <= 1'b1;
                state        <= ST_EMIT;
              end
            endcase
          end else if (wait_cnt == WAIT_LAST) begin
            err_q      <= 1'b1;
            clk_en_q   <= 1'b0;
            op_q       <= OP_ADD;
            dataa_q    <= '0;
            datab_q    <= '0;
            wait_cnt   <= '0;
            in_ready_q <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_GAP1: begin
          op_q     <= OP_MUL;
          clk_en_q <= 1'b1;
          state    <= ST_MUL;
        end
        ST_GAP2: begin
          op_q     <= OP_F2I;
          clk_en_q <= 1'b1;
          state    <= ST_F2I;
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_gain_sequencer.sv
// Directed bench for fp_gain_sequencer with a behavioural float unit whose
// per-op latency is programmable; expected results are hand-computed.
module tb_fp_gain_sequencer;
  localparam int SW = 24;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fp_gain_sequencer_if #(.SAMPLE_W(SW)) bus ();

  fp_gain_sequencer #(.SAMPLE_W(SW), .TIMEOUT_CYC(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural float unit ----------------
  int lat_i2f = 5, lat_mul = 5, lat_f2i = 5;
  bit hang_mul = 1'b0;
  int en_cnt = 0;
  int cur_lat;

  function automatic real sp2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    real r;
    case (op)
      3'd5: return r2sp($itor($signed(a)));
      3'd3: return r2sp(sp2r(a) * sp2r(b));
      3'd4: begin
        r = sp2r(a);
        if (r >= 2147483647.0) return 32'h7fffffff;
        if (r <= -2147483648.0) return 32'h80000000;
        return 32'($rtoi(r));
      end
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    case (bus.fp_operation)
      3'd5:    cur_lat = lat_i2f;
      3'd3:    cur_lat = lat_mul;
      default: cur_lat = lat_f2i;
    endcase
  end

  assign bus.fp_done = bus.fp_clk_en && !(hang_mul && bus.fp_operation == 3'd3)
                       && (en_cnt == cur_lat - 1);
  assign bus.fp_result = model_result(bus.fp_operation, bus.fp_dataa, bus.fp_datab);

  always @(posedge clock) en_cnt <= bus.fp_clk_en ? en_cnt + 1 : 0;

  // ---------------- enable-gap / operand-stability monitor ----------------
  int stab_viol = 0, gap_viol = 0, gap_checks = 0, zero_run = 0;
  logic prev_en = 1'b0;
  logic [31:0] pa, pb;
  logic [2:0] pop;

  always @(posedge clock) begin
    if (!reset_n) begin
      prev_en  = 1'b0;
      zero_run = 0;
    end else begin
      if (bus.fp_clk_en && prev_en &&
          (bus.fp_dataa != pa || bus.fp_datab != pb || bus.fp_operation != pop))
        stab_viol++;
      if (bus.fp_clk_en && !prev_en && bus.fp_operation != 3'd5) begin
        gap_checks++;
        if (zero_run != 1) gap_viol++;
      end
      zero_run = bus.fp_clk_en ? 0 : zero_run + 1;
      prev_en  = bus.fp_clk_en;
      pa  = bus.fp_dataa;
      pb  = bus.fp_datab;
      pop = bus.fp_operation;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [SW-1:0] s, input logic [31:0] g);
    int n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    check("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.gain      = g;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_sample = SW'($urandom);
    bus.gain      = $urandom;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 300) begin tick(); cyc++; end
  endtask

  task automatic collect(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_valid_after"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  int lat, mul_cyc, err_cnt, n;
  bit seen_ov, stable, ready_at_err;
  logic [SW-1:0] held;

  initial begin
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.gain = '0; bus.out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_sample", {40'd0, bus.out_sample}, 64'd0);
    check("rst_clk_en",    {63'd0, bus.fp_clk_en}, 64'd0);
    check("rst_op",        {61'd0, bus.fp_operation}, 64'd0);
    check("rst_dataa",     {32'd0, bus.fp_dataa}, 64'd0);
    check("rst_datab",     {32'd0, bus.fp_datab}, 64'd0);
    check("rst_err",       {63'd0, bus.err}, 64'd0);
    reset_n = 1'b1;
    tick();

    // 1000 * 2.0, all latencies 5
    accept(24'd1000, 32'h40000000);
    wait_out(lat);
    check("t1_latency", 64'(lat), 64'd17);
    check("t1_sample", {40'd0, bus.out_sample}, 64'd2000);
    collect("t1");

    // positive saturation, back-to-back accept
    accept(24'd4194304, 32'h40000000);
    wait_out(lat);
    check("t2_latency", 64'(lat), 64'd17);
    check("t2_sample", {40'd0, bus.out_sample}, 64'h7fffff);
    collect("t2");

    // negative saturation with uneven latencies: 1+3+2+2
    lat_i2f = 1; lat_mul = 3; lat_f2i = 2;
    accept(24'hC00000, 32'h40400000);
    wait_out(lat);
    check("t3_latency", 64'(lat), 64'd8);
    check("t3_sample", {40'd0, bus.out_sample}, 64'h800000);
    collect("t3");
    lat_i2f = 5; lat_mul = 5; lat_f2i = 5;

    // downstream stall: -300 * 2.0 = -600
    accept(24'hFFFED4, 32'h40000000);
    wait_out(lat);
    check("t4_latency", 64'(lat), 64'd17);
    held = bus.out_sample;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.out_sample !== held || bus.in_ready) stable = 1'b0;
    end
    check("t4_stall_stable", {63'd0, stable}, 64'd1);
    check("t4_sample", {40'd0, bus.out_sample}, 64'hFFFDA8);
    collect("t4");

    // float unit never completes MUL
    hang_mul = 1'b1;
    mul_cyc = 0; err_cnt = 0; seen_ov = 1'b0; ready_at_err = 1'b0;
    accept(24'd1000, 32'h40000000);
    for (int i = 0; i < 120; i++) begin
      if (bus.fp_clk_en && bus.fp_operation == 3'd3) mul_cyc++;
      if (bus.err) begin
        if (err_cnt == 0) ready_at_err = bus.in_ready;
        err_cnt++;
      end
      if (bus.out_valid) seen_ov = 1'b1;
      tick();
    end
    check("t5_mul_cycles", 64'(mul_cyc), 64'd64);
    check("t5_err_pulses", 64'(err_cnt), 64'd1);
    check("t5_idle_at_err", {63'd0, ready_at_err}, 64'd1);
    check("t5_no_out_valid", {63'd0, seen_ov}, 64'd0);
    check("t5_clk_en_off", {63'd0, bus.fp_clk_en}, 64'd0);
    hang_mul = 1'b0;

    // reset asserted for one cycle in the middle of F2I
    accept(24'd1000, 32'h40000000);
    n = 0;
    while (!(bus.fp_clk_en && bus.fp_operation == 3'd4) && n < 100) begin tick(); n++; end
    check("t6_reached_f2i", {61'd0, bus.fp_operation}, 64'd4);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    check("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_clk_en",    {63'd0, bus.fp_clk_en}, 64'd0);
    check("t6_op",        {61'd0, bus.fp_operation}, 64'd0);
    check("t6_operands",  {bus.fp_dataa, bus.fp_datab}, 64'd0);
    check("t6_err",       {63'd0, bus.err}, 64'd0);
    seen_ov = 1'b0; err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen_ov = 1'b1;
      if (bus.err) err_cnt++;
    end
    check("t6_abandoned", {62'd0, seen_ov, err_cnt != 0}, 64'd0);
    accept(24'd1000, 32'h3F000000);
    wait_out(lat);
    check("t6_latency", 64'(lat), 64'd17);
    check("t6_sample", {40'd0, bus.out_sample}, 64'd500);
    collect("t6");

    check("gap_violations", 64'(gap_viol), 64'd0);
    check("gap_checks", 64'(gap_checks), 64'd13);
    check("operand_stability", 64'(stab_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
